taylor_out_fifo: RTL

Output-side collector for the Taylor-network processor subsystem. It sits directly downstream of the float-to-int conversion and the output address decoder. It captures each converted result word together with the output port index it was written to, and queues both in a first-word-fall-through FIFO. A downstream consumer (host interface, logger, DAC driver) can then drain results at its own pace without stalling the processor.

---
 rtl/taylor_out_fifo.sv | 105 ++++++++++
 1 files changed

// File: rtl/taylor_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : taylor_out_fifo
// Description : Tags each converted Taylor-network result with its output
//               port index and queues it in a first-word-fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module taylor_out_fifo #(
  parameter int NBITS = 28,
  parameter int NCH   = 4,
  parameter int CHW   = 2,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] io_out,
  input  logic [NCH-1:0]   out_en,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [NBITS-1:0] dout,
  output logic [CHW-1:0]   dout_ch,
  output logic             dout_valid,
  output logic             full,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             onehot_err
);

  localparam int          c_depth_i = 2 ** AW;
  localparam int          c_ew      = NBITS + CHW;
  localparam logic [AW:0] c_depth   = (AW+1)'(c_depth_i);

  logic [c_ew-1:0] r_mem [c_depth_i];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_overflow;
  logic            r_onehot_err;

  logic [CHW-1:0]  w_tag;
  logic            w_any;
  logic            w_multi;
  logic            w_wr_req;
  logic            w_pop;
  logic            w_wr;
  logic            w_full;
  logic            w_ovf_evt;

  // Clearing the lowest set bit leaves a nonzero value only if 2+ bits are set.
  assign w_any   = |out_en;
  assign w_multi = |(out_en & (out_en - NCH'(1)));

  always_comb begin
    w_tag = '0;
    for (int k = 0; k < NCH; k++) begin
      if (out_en[k]) w_tag = CHW'(k);
    end
  end

  assign w_full    = (r_count == c_depth);
  assign w_wr_req  = w_any && !w_multi;
  assign w_pop     = rd_en && (r_count != '0);
  assign w_wr      = w_wr_req && (!w_full || w_pop);
  assign w_ovf_evt = w_wr_req && w_full && !w_pop;

  // Storage is deliberately not reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_tag, io_out};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_onehot_err <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase

      // A fresh error in the clearing cycle wins over err_clr.
      if (w_ovf_evt)    r_overflow <= 1'b1;
      else if (err_clr) r_overflow <= 1'b0;

      if (w_multi)      r_onehot_err <= 1'b1;
      else if (err_clr) r_onehot_err <= 1'b0;
    end
  end

  assign {dout_ch, dout} = r_mem[r_rd_ptr];
  assign dout_valid      = (r_count != '0);
  assign full            = w_full;
  assign count           = r_count;
  assign overflow        = r_overflow;
  assign onehot_err      = r_onehot_err;

endmodule
`default_nettype wire
